row_softmax: RTL
================

Name: row_softmax

Overview:
- Attention stage directly downstream of the Q·K^T score multiplier.
- Consumes the flat SEQ_LEN×SEQ_LEN signed fixed-point score matrix and applies a numerically stable softmax to each row.
- Each row is processed as: max-subtract, base-2 exp approximation, then normalisation by a sequential divider.
- Produces a flat probability matrix in the same Q format, ready for the P·V multiplier.

Parameters:
- DATA_WIDTH, 32, element width (signed, two's complement)
- SEQ_LEN, 64, rows and columns of the score matrix
- FRAC_BITS, 14, fractional bits; ONE = 1<<FRAC_BITS
- LOG2E, 23637, log2(e) in Q(FRAC_BITS)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin processing; sampled only in IDLE
- scores_flat  in  DATA_WIDTH*SEQ_LEN*SEQ_LEN  element [m][n] at bits (m*SEQ_LEN+n)*DATA_WIDTH +: DATA_WIDTH; must stay stable from start until done
- done  out  1  one-cycle pulse when all rows are written
- probs_flat  out  DATA_WIDTH*SEQ_LEN*SEQ_LEN  same packing as scores_flat; unsigned values in [0, ONE]

Behaviour:
- Reset (asynchronous):
  - state=IDLE, done=0, all probs=0.
  - Row/column counters, max, sum and divider are cleared.
  - Reset mid-operation aborts the run immediately; no done pulse follows.
- IDLE:
  - done<=0.
  - start=1 → i=0, j=0, go to MAX.
  - start in any other state is ignored.
- MAX (SEQ_LEN cycles):
  - One element per cycle; rmax = signed max of row i.
  - rmax initialises from element [i][0].
- EXP (SEQ_LEN cycles):
  - One element per cycle; x = s[i][j] - rmax, so x <= 0.
  - y = (x*LOG2E)>>>FRAC_BITS, using a 2*DATA_WIDTH signed product.
  - ip = y>>>FRAC_BITS (floor); fp = y - (ip<<FRAC_BITS), range [0, ONE).
  - sh = -ip; e = (sh >= DATA_WIDTH-1) ? 0 : (ONE+fp)>>sh.
  - e[j] is stored in a SEQ_LEN-entry row buffer.
  - sum += e; sum width is DATA_WIDTH+$clog2(SEQ_LEN) and must not overflow.
  - The max element gives e=ONE, so sum >= ONE and there is never a divide-by-zero.
- DIV_ISSUE (1 cycle): pulse the divider start with dividend = e[j]<<FRAC_BITS, divisor = sum.
- DIV_WAIT:
  - Divider done arrives exactly DATA_WIDTH cycles after start.
  - On done: probs[i][j] <= quotient (truncating; quotient <= ONE).
  - If j < SEQ_LEN-1: j++ and return to DIV_ISSUE.
  - Otherwise, if i < SEQ_LEN-1: i++, j=0, go to MAX.
  - Otherwise: done<=1, go to IDLE.
- Latency:
  - Per row: 2*SEQ_LEN + SEQ_LEN*(DATA_WIDTH+2) cycles.
  - Total: done is registered SEQ_LEN*(that)+1 cycles after the start edge, i.e. 147457 at defaults.
- probs_flat is driven continuously from the probs register array and updates element-by-element during a run.
- Back-to-back: start is accepted on the cycle immediately after the done pulse (state is IDLE).

Optional Feature:
- Macro: CAUSAL_MASK_EN.
- Defined:
  - Elements with j > i are excluded from the MAX pass and forced to e=0 in EXP, so probs[i][j]=0 for j > i.
  - Row 0 therefore yields probs[0][0]=ONE.
  - Cycle count is unchanged.
- Undefined: every element participates; no mask logic is synthesised.

Decomposition:
- Package attn_pkg holds:
  - the FRAC_BITS/ONE/LOG2E constants;
  - the state enum softmax_state_t (IDLE, MAX, EXP, DIV_ISSUE, DIV_WAIT);
  - the sum-width localparam function.
- One sub-module, seq_divider: restoring unsigned divider.
  - Ports: clk, rst, start, dividend[2*DATA_WIDTH], divisor[DATA_WIDTH+$clog2(SEQ_LEN)], quotient[DATA_WIDTH], done.
  - One quotient bit per cycle; fixed DATA_WIDTH-cycle latency.

Test Plan:
- SEQ_LEN=2, row [0,0] → probs 8192, 8192; done exactly 2*(4+2*34)+1 = 145 cycles after start.
- SEQ_LEN=2, row [16384,0] → intermediate values e=[16384,6378], sum=22762; probs=[11793,4590].
- Defaults, all scores 0 → every prob = 256; done pulses for exactly one cycle after 147457 cycles.
- One-hot row (element 5 = 40*ONE, others 0) → prob[5]=16384 and the rest 0 (shift clamp exercised).
- CAUSAL_MASK_EN, SEQ_LEN=2, all-zero scores → row0=[16384,0], row1=[8192,8192].
- Assert rst mid-DIV_WAIT → probs all 0, no done pulse; start during a run is ignored; a new start after reset completes normally.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared fixed-point constants, FSM state type and sizing helpers for the attention softmax.
package attn_pkg;

   localparam int unsigned FRAC_BITS = 14;
   localparam int unsigned ONE       = 1 << FRAC_BITS;
   localparam int unsigned LOG2E     = 23637;

   typedef enum logic [2:0] {
      IDLE,
      MAX,
      EXP,
      DIV_ISSUE,
      DIV_WAIT
   } softmax_state_t;

   // Row sum of up to n values each <= ONE, kept in the element width plus growth bits.
   function automatic int unsigned sum_width(input int unsigned dw, input int unsigned n);
      return dw + $clog2(n);
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, fixed DATA_WIDTH-cycle latency.
module seq_divider #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SUM_WIDTH  = 38
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2*DATA_WIDTH-1:0] dividend,
   input  logic [SUM_WIDTH-1:0]    divisor,
   output logic [DATA_WIDTH-1:0]   quotient,
   output logic                    done
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

   logic [SUM_WIDTH-1:0]  rem_q, rem_d, dsr_q, dsr_d;
   logic [DATA_WIDTH-1:0] low_q, low_d, quo_q, quo_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [SUM_WIDTH:0]    trial;

   always_comb begin
      rem_d  = rem_q;
      dsr_d  = dsr_q;
      low_d  = low_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      trial  = {rem_q, low_q[DATA_WIDTH-1]};
      if (start) begin
         // Upper half seeds the remainder; callers keep it below the divisor.
         rem_d  = SUM_WIDTH'(dividend[2*DATA_WIDTH-1:DATA_WIDTH]);
         low_d  = dividend[DATA_WIDTH-1:0];
         dsr_d  = divisor;
         quo_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (trial >= {1'b0, dsr_q}) begin
            rem_d = SUM_WIDTH'(trial - {1'b0, dsr_q});
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
         end else begin
            rem_d = trial[SUM_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
         end
         low_d = low_q << 1;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         dsr_q  <= '0;
         low_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
         low_q  <= low_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign quotient = quo_q;
   assign done     = done_q;

endmodule

// File: rtl/row_softmax.sv
// Row-wise numerically stable softmax over a flat score matrix (max-subtract, base-2 exp, divide).
// Define CAUSAL_MASK_EN to zero out every element above the diagonal.
module row_softmax #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SEQ_LEN    = 64,
   parameter int unsigned FRAC_BITS  = attn_pkg::FRAC_BITS,
   parameter int unsigned LOG2E      = attn_pkg::LOG2E
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] scores_flat,
   output logic                                   done,
   output logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] probs_flat
);

   import attn_pkg::*;

   localparam int unsigned SumW  = sum_width(DATA_WIDTH, SEQ_LEN);
   localparam int unsigned IdxW  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int unsigned ElemW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN * SEQ_LEN) : 1;
   localparam int unsigned PW    = 2 * DATA_WIDTH;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(SEQ_LEN - 1);

   softmax_state_t state_q, state_d;
   logic [IdxW-1:0]              i_q, i_d, j_q, j_d;
   logic signed [DATA_WIDTH-1:0] rmax_q, rmax_d;
   logic [SumW-1:0]              sum_q, sum_d;
   logic                         done_q, done_d;
   logic [DATA_WIDTH-1:0]        ebuf_q [SEQ_LEN];
   logic [DATA_WIDTH-1:0]        probs_q [SEQ_LEN*SEQ_LEN];

   logic [ElemW-1:0]             elem_idx;
   logic signed [DATA_WIDTH-1:0] s_cur, diff;
   logic signed [PW-1:0]         x_w, prod_w, y_w, ip_w, sh_w;
   logic [FRAC_BITS-1:0]         fp_w;
   logic [DATA_WIDTH-1:0]        mant_w, e_w;
   logic                         excl;
   logic                         ebuf_we, prob_we, div_start, div_done;
   logic [DATA_WIDTH-1:0]        quotient;

   always_comb begin
      elem_idx = ElemW'(int'(i_q) * int'(SEQ_LEN) + int'(j_q));
      s_cur    = scores_flat[int'(elem_idx)*DATA_WIDTH +: DATA_WIDTH];
      diff     = s_cur - rmax_q;
      x_w      = {{DATA_WIDTH{diff[DATA_WIDTH-1]}}, diff};
      prod_w   = x_w * $signed(PW'(LOG2E));
      y_w      = prod_w >>> FRAC_BITS;
      ip_w     = y_w >>> FRAC_BITS;
      fp_w     = y_w[FRAC_BITS-1:0];
      sh_w     = -ip_w;
      // {1, fp} is ONE + fp; large shifts clamp to zero instead of wrapping the shifter.
      mant_w   = DATA_WIDTH'({1'b1, fp_w});
      e_w      = (sh_w >= $signed(PW'(DATA_WIDTH - 1))) ? '0 : (mant_w >> sh_w);
`ifdef CAUSAL_MASK_EN
      excl     = (j_q > i_q);
`else
      excl     = 1'b0;
`endif
      if (excl) e_w = '0;
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      rmax_d    = rmax_q;
      sum_d     = sum_q;
      done_d    = 1'b0;
      ebuf_we   = 1'b0;
      prob_we   = 1'b0;
      div_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               state_d = MAX;
            end
         end
         MAX: begin
            if (j_q == '0) rmax_d = s_cur;
            else if (!excl && (s_cur > rmax_q)) rmax_d = s_cur;
            if (j_q == LastIdx) begin
               j_d     = '0;
               sum_d   = '0;
               state_d = EXP;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         EXP: begin
            ebuf_we = 1'b1;
            sum_d   = sum_q + SumW'(e_w);
            if (j_q == LastIdx) begin
               j_d     = '0;
               state_d = DIV_ISSUE;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         DIV_ISSUE: begin
            div_start = 1'b1;
            state_d   = DIV_WAIT;
         end
         DIV_WAIT: begin
            if (div_done) begin
               prob_we = 1'b1;
               if (j_q != LastIdx) begin
                  j_d     = j_q + 1'b1;
                  state_d = DIV_ISSUE;
               end else if (i_q != LastIdx) begin
                  i_d     = i_q + 1'b1;
                  j_d     = '0;
                  state_d = MAX;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         rmax_q  <= '0;
         sum_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rmax_q  <= rmax_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SEQ_LEN; k++) ebuf_q[k] <= '0;
         for (int k = 0; k < SEQ_LEN*SEQ_LEN; k++) probs_q[k] <= '0;
      end else begin
         if (ebuf_we) ebuf_q[j_q] <= e_w;
         if (prob_we) probs_q[elem_idx] <= quotient;
      end
   end

   seq_divider #(
      .DATA_WIDTH (DATA_WIDTH),
      .SUM_WIDTH  (SumW)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (PW'(ebuf_q[j_q]) << FRAC_BITS),
      .divisor  (sum_q),
      .quotient (quotient),
      .done     (div_done)
   );

   for (genvar k = 0; k < SEQ_LEN*SEQ_LEN; k++) begin : g_out
      assign probs_flat[k*DATA_WIDTH +: DATA_WIDTH] = probs_q[k];
   end

   assign done = done_q;

endmodule
